// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared commands, FSM encoding and window decode for mem_xbar_ctrl
package mem_pkg;

    localparam logic [7:0]  CMD_READ      = 8'h01;
    localparam logic [7:0]  CMD_WRITE     = 8'h02;

    localparam logic [31:0] DEF_SRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_SRAM_SIZE = 32'h0008_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_MMIO_SIZE = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRAM_WAIT,
        ST_MMIO_WAIT,
        ST_RESP
    } state_t;

    // Unsigned wrap lets a single compare cover both window bounds.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr - base) < size;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant starting after last_grant
module rr_arbiter
    import mem_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    localparam int IW        = idx_width(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IW-1:0]        last_grant,
    input  logic                 enable,
    output logic [N_MASTERS-1:0] grant,
    output logic [IW-1:0]        index
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            j = (int'(last_grant) + k) % N_MASTERS;
            if (enable && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_xbar_ctrl.sv
// rtl/mem_xbar_ctrl.sv - N-master to SRAM/MMIO controller with round-robin grant and timeout
module mem_xbar_ctrl
    import mem_pkg::*;
#(
    parameter int          N_MASTERS = 2,
    parameter logic [31:0] SRAM_BASE = DEF_SRAM_BASE,
    parameter logic [31:0] SRAM_SIZE = DEF_SRAM_SIZE,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_MASTERS-1:0]    m_valid,
    output logic [N_MASTERS-1:0]    m_ready,
    output logic [N_MASTERS-1:0]    m_err,
    input  logic [32*N_MASTERS-1:0] m_addr,
    input  logic [32*N_MASTERS-1:0] m_wdata,
    input  logic [4*N_MASTERS-1:0]  m_wstrb,
    output logic [31:0]             m_rdata,
    output logic                    sram_start,
    input  logic                    sram_busy,
    input  logic                    sram_done,
    output logic [7:0]              sram_cmd,
    output logic [31:0]             sram_addr,
    output logic [31:0]             sram_wdata,
    output logic [3:0]              sram_wstrb,
    input  logic [31:0]             sram_rdata,
    output logic                    mmio_valid,
    output logic                    mmio_write,
    output logic [31:0]             mmio_addr,
    output logic [31:0]             mmio_wdata,
    output logic [3:0]              mmio_wstrb,
    input  logic [31:0]             mmio_rdata,
    input  logic                    mmio_ready,
    output logic [15:0]             err_count
);

    localparam int                   IW  = idx_width(N_MASTERS);
    localparam int                   CW  = $clog2(TIMEOUT);
    localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

    state_t               state;
    logic [IW-1:0]        last_grant, cap_idx, arb_idx;
    logic [N_MASTERS-1:0] sram_hit, mmio_hit, req, arb_grant;
    logic [31:0]          sel_addr, sel_wdata, cap_addr, cap_wdata;
    logic [3:0]           sel_wstrb, cap_wstrb;
    logic [CW-1:0]        wait_cnt;
    logic [15:0]          err_inc;
    logic                 wait_done;
    logic [31:0]          wait_rdata;

    // An SRAM-bound master stays pending while the SRAM is busy; others may still win.
    always_comb begin
        sram_hit = '0;
        mmio_hit = '0;
        req      = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            sram_hit[i] = in_window(m_addr[32*i +: 32], SRAM_BASE, SRAM_SIZE);
            mmio_hit[i] = !sram_hit[i] && in_window(m_addr[32*i +: 32], MMIO_BASE, MMIO_SIZE);
            req[i]      = m_valid[i] && !(sram_hit[i] && sram_busy);
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_addr  = m_addr[32*i +: 32];
                sel_wdata = m_wdata[32*i +: 32];
                sel_wstrb = m_wstrb[4*i +: 4];
            end
        end
    end

    rr_arbiter #(.N_MASTERS(N_MASTERS)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .enable     (state == ST_IDLE),
        .grant      (arb_grant),
        .index      (arb_idx)
    );

    assign wait_done  = (state == ST_SRAM_WAIT) ? sram_done  : mmio_ready;
    assign wait_rdata = (state == ST_SRAM_WAIT) ? sram_rdata : mmio_rdata;
    assign err_inc    = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    assign sram_addr  = cap_addr;
    assign sram_wdata = cap_wdata;
    assign sram_wstrb = cap_wstrb;
    assign mmio_addr  = cap_addr;
    assign mmio_wdata = cap_wdata;
    assign mmio_wstrb = cap_wstrb;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= IW'(N_MASTERS - 1);
            cap_idx    <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            wait_cnt   <= '0;
            m_ready    <= '0;
            m_err      <= '0;
            m_rdata    <= '0;
            sram_start <= 1'b0;
            sram_cmd   <= '0;
            mmio_valid <= 1'b0;
            mmio_write <= 1'b0;
            err_count  <= '0;
        end else begin
            sram_start <= 1'b0;
            mmio_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|arb_grant) begin
                        cap_idx   <= arb_idx;
                        cap_addr  <= sel_addr;
                        cap_wdata <= sel_wdata;
                        cap_wstrb <= sel_wstrb;
                        wait_cnt  <= '0;
                        if (sram_hit[arb_idx]) begin
                            sram_start <= 1'b1;
                            sram_cmd   <= (sel_wstrb != 4'h0) ? CMD_WRITE : CMD_READ;
                            state      <= ST_SRAM_WAIT;
                        end else if (mmio_hit[arb_idx]) begin
                            mmio_valid <= 1'b1;
                            mmio_write <= (sel_wstrb != 4'h0);
                            state      <= ST_MMIO_WAIT;
                        end else begin
                            m_ready   <= arb_grant;
                            m_err     <= arb_grant;
                            m_rdata   <= '0;
                            err_count <= err_inc;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_SRAM_WAIT, ST_MMIO_WAIT: begin
                    // Completion wins over a coincident timeout.
                    if (wait_done) begin
                        m_ready <= ONE << cap_idx;
                        m_rdata <= wait_rdata;
                        state   <= ST_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        m_ready   <= ONE << cap_idx;
                        m_err     <= ONE << cap_idx;
                        m_rdata   <= '0;
                        err_count <= err_inc;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    m_ready    <= '0;
                    m_err      <= '0;
                    m_rdata    <= '0;
                    last_grant <= cap_idx;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_xbar_ctrl.sv
// tb/tb_mem_xbar_ctrl.sv - directed bench for mem_xbar_ctrl with a transaction-level expectation model
`timescale 1ns/1ps
module tb_mem_xbar_ctrl;

    localparam int N  = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    m_valid, m_ready, m_err;
    logic [32*N-1:0] m_addr, m_wdata;
    logic [4*N-1:0]  m_wstrb;
    logic [31:0]     m_rdata;
    logic            sram_start, sram_busy, sram_done;
    logic [7:0]      sram_cmd;
    logic [31:0]     sram_addr, sram_wdata, sram_rdata;
    logic [3:0]      sram_wstrb;
    logic            mmio_valid, mmio_write, mmio_ready;
    logic [31:0]     mmio_addr, mmio_wdata, mmio_rdata;
    logic [3:0]      mmio_wstrb;
    logic [15:0]     err_count;

    always #5 clk = ~clk;

    mem_xbar_ctrl #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_err(m_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .sram_start(sram_start), .sram_busy(sram_busy), .sram_done(sram_done),
        .sram_cmd(sram_cmd), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata),
        .mmio_valid(mmio_valid), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata),
        .mmio_ready(mmio_ready), .err_count(err_count)
    );

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } bus_t;
    typedef struct { int idx; logic [31:0] rdata; logic err; } resp_t;

    bus_t  mq0[$], mq1[$], exp_sram[$], exp_mmio[$];
    resp_t exp_resp[$];
    int    checks = 0, errors = 0, cyc = 0, model_err = 0;
    int    start_cyc = 0, mmio_cyc = 0, ready_cyc = 0, v_cyc = 0, busy_drop = 0;
    int    sram_lat = 3, mmio_lat = 1, s_cnt = 0, m_cnt = 0;
    logic [31:0] sram_data = '0, mmio_data = '0;
    bus_t  b, b0, b1;

    // Address map as plain ranges: 1 = SRAM, 2 = MMIO, 0 = unmapped.
    function automatic int region(input logic [31:0] a);
        if (longint'(a) < 64'h0008_0000) return 1;
        if (longint'(a) >= 64'h8000_0000 && longint'(a) < 64'h8000_0100) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_req(input int idx, input bus_t rq, input logic [31:0] rd, input bit completes);
        int r;
        r = region(rq.addr);
        if (r == 1) exp_sram.push_back(rq);
        if (r == 2) exp_mmio.push_back(rq);
        if (r != 0 && completes) exp_resp.push_back('{idx: idx, rdata: rd, err: 1'b0});
        else                     exp_resp.push_back('{idx: idx, rdata: 32'h0, err: 1'b1});
    endtask

    task automatic monitor();
        bus_t  e;
        resp_t r;
        if (!resetn) begin
            model_err = 0;
        end else begin
            if (sram_start) begin
                start_cyc = cyc;
                if (exp_sram.size() == 0) chk("sram_start_unexpected", 32'(sram_start), 32'h0);
                else begin
                    e = exp_sram.pop_front();
                    chk("sram_addr", sram_addr, e.addr);
                    chk("sram_cmd", 32'(sram_cmd), (e.wstrb != 4'h0) ? 32'h2 : 32'h1);
                    chk("sram_wdata", sram_wdata, e.wdata);
                    chk("sram_wstrb", 32'(sram_wstrb), 32'(e.wstrb));
                end
            end
            if (mmio_valid) begin
                mmio_cyc = cyc;
                if (exp_mmio.size() == 0) chk("mmio_valid_unexpected", 32'(mmio_valid), 32'h0);
                else begin
                    e = exp_mmio.pop_front();
                    chk("mmio_addr", mmio_addr, e.addr);
                    chk("mmio_write", 32'(mmio_write), 32'(e.wstrb != 4'h0));
                    chk("mmio_wdata", mmio_wdata, e.wdata);
                    chk("mmio_wstrb", 32'(mmio_wstrb), 32'(e.wstrb));
                end
            end
            if (|m_ready) begin
                ready_cyc = cyc;
                if (exp_resp.size() == 0) chk("m_ready_unexpected", 32'(m_ready), 32'h0);
                else begin
                    r = exp_resp.pop_front();
                    chk("m_ready", 32'(m_ready), 32'(1) << r.idx);
                    chk("m_err", 32'(m_err), r.err ? (32'(1) << r.idx) : 32'h0);
                    chk("m_rdata", m_rdata, r.rdata);
                    if (r.err && model_err < 65535) model_err++;
                end
            end else begin
                chk("m_err_without_ready", 32'(m_err), 32'h0);
            end
            chk("err_count", 32'(err_count), 32'(model_err));
        end
    endtask

    task automatic drive();
        if (!resetn) begin
            mq0.delete();
            mq1.delete();
        end
        if (m_ready[0] && mq0.size() > 0) void'(mq0.pop_front());
        if (m_ready[1] && mq1.size() > 0) void'(mq1.pop_front());
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        if (mq0.size() > 0) begin
            m_valid[0] = 1'b1; m_addr[31:0] = mq0[0].addr;
            m_wdata[31:0] = mq0[0].wdata; m_wstrb[3:0] = mq0[0].wstrb;
        end
        if (mq1.size() > 0) begin
            m_valid[1] = 1'b1; m_addr[63:32] = mq1[0].addr;
            m_wdata[63:32] = mq1[0].wdata; m_wstrb[7:4] = mq1[0].wstrb;
        end
        sram_done = 1'b0; mmio_ready = 1'b0;
        sram_rdata = sram_data; mmio_rdata = mmio_data;
        if (s_cnt > 0) begin s_cnt--; sram_done = (s_cnt == 0); end
        if (m_cnt > 0) begin m_cnt--; mmio_ready = (m_cnt == 0); end
        if (sram_start && sram_lat > 0) s_cnt = sram_lat;
        if (mmio_valid && mmio_lat > 0) m_cnt = mmio_lat;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        drive();
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((exp_sram.size() + exp_mmio.size() + exp_resp.size() + mq0.size() + mq1.size()) != 0
               && n < budget) begin
            step();
            n++;
        end
        chk("wait_budget", 32'(exp_sram.size() + exp_mmio.size() + exp_resp.size()), 32'h0);
        repeat (2) step();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) step();
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_err", 32'(m_err), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_sram_start", 32'(sram_start), 32'h0);
        chk("rst_sram_cmd", 32'(sram_cmd), 32'h0);
        chk("rst_mmio_valid", 32'(mmio_valid), 32'h0);
        chk("rst_mmio_write", 32'(mmio_write), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn = 1'b0; sram_busy = 1'b0;
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        sram_done = 1'b0; mmio_ready = 1'b0; sram_rdata = '0; mmio_rdata = '0;
        do_reset();

        // Single-master SRAM read, done three cycles after start
        sram_lat = 3; sram_data = 32'hCAFE_0001;
        b = '{addr: 32'h0000_0010, wdata: 32'h0, wstrb: 4'h0};
        mq0.push_back(b); expect_req(0, b, 32'hCAFE_0001, 1);
        wait_all(40);
        chk("sram_read_latency", 32'(ready_cyc - start_cyc), 32'd4);

        // Two masters valid continuously alternate 0,1,0,1
        do_reset();
        mmio_lat = 1; mmio_data = 32'h1234_5678;
        b0 = '{addr: 32'h8000_0000, wdata: 32'h0, wstrb: 4'h0};
        b1 = '{addr: 32'h8000_0010, wdata: 32'h0, wstrb: 4'h0};
        mq0.push_back(b0); mq1.push_back(b1);
        expect_req(0, b0, 32'h1234_5678, 1); expect_req(1, b1, 32'h1234_5678, 1);
        b0.addr = 32'h8000_0008; b1.addr = 32'h8000_0014;
        mq0.push_back(b0); mq1.push_back(b1);
        expect_req(0, b0, 32'h1234_5678, 1); expect_req(1, b1, 32'h1234_5678, 1);
        wait_all(80);

        // Unmapped read answers the cycle after grant with an error
        b = '{addr: 32'h4000_0000, wdata: 32'h0, wstrb: 4'h0};
        mq0.push_back(b); expect_req(0, b, 32'h0, 1);
        step(); v_cyc = cyc;
        wait_all(20);
        chk("unmapped_latency", 32'(ready_cyc - v_cyc), 32'd1);
        chk("unmapped_err_count", 32'(err_count), 32'd1);

        // MMIO write never acknowledged times out after TIMEOUT cycles
        mmio_lat = 0;
        b = '{addr: 32'h8000_0004, wdata: 32'hA5A5_A5A5, wstrb: 4'hF};
        mq1.push_back(b); expect_req(1, b, 32'h0, 0);
        wait_all(60);
        chk("timeout_latency", 32'(ready_cyc - mmio_cyc), 32'(TO));
        chk("timeout_err_count", 32'(err_count), 32'd2);
        step(); mmio_ready = 1'b1;
        repeat (6) step();
        chk("late_ready_err_count", 32'(err_count), 32'd2);

        // SRAM busy: MMIO master completes first, SRAM master starts after busy drops
        sram_busy = 1'b1; sram_lat = 2; sram_data = 32'h7777_0000;
        mmio_lat = 2; mmio_data = 32'h5555_0000;
        b0 = '{addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0};
        b1 = '{addr: 32'h8000_0020, wdata: 32'h0, wstrb: 4'h0};
        mq0.push_back(b0); mq1.push_back(b1);
        expect_req(1, b1, 32'h5555_0000, 1); expect_req(0, b0, 32'h7777_0000, 1);
        for (int n = 0; n < 50 && exp_resp.size() > 1; n++) step();
        chk("busy_mmio_first", 32'(exp_resp.size()), 32'd1);
        repeat (4) step();
        busy_drop = cyc; sram_busy = 1'b0;
        wait_all(40);
        chk("busy_sram_start_after_drop", 32'(start_cyc - busy_drop), 32'd1);

        // Reset during SRAM_WAIT abandons the write; late done is ignored
        sram_lat = 4;
        b = '{addr: 32'h0000_0200, wdata: 32'hDEAD_BEEF, wstrb: 4'h3};
        mq0.push_back(b); exp_sram.push_back(b);
        for (int n = 0; n < 20 && exp_sram.size() > 0; n++) step();
        chk("rst_wait_start_seen", 32'(exp_sram.size()), 32'h0);
        step();
        resetn = 1'b0;
        step();
        chk("midrst_m_ready", 32'(m_ready), 32'h0);
        chk("midrst_sram_start", 32'(sram_start), 32'h0);
        chk("midrst_sram_cmd", 32'(sram_cmd), 32'h0);
        chk("midrst_sram_addr", sram_addr, 32'h0);
        chk("midrst_sram_wdata", sram_wdata, 32'h0);
        chk("midrst_sram_wstrb", 32'(sram_wstrb), 32'h0);
        chk("midrst_err_count", 32'(err_count), 32'h0);
        resetn = 1'b1;
        repeat (10) step();
        chk("midrst_no_ready", 32'(m_ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_xbar_ctrl.md
MEM_XBAR_CTRL -- requirements
Module: mem_xbar_ctrl

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 2, number of requesting masters (1..8).
REQ-002 The block SHALL have parameter SRAM_BASE, default 32'h00000000, SRAM window base.
REQ-003 The block SHALL have parameter SRAM_SIZE, default 32'h00080000, SRAM window size in bytes (power of two).
REQ-004 The block SHALL have parameter MMIO_BASE, default 32'h80000000, MMIO window base.
REQ-005 The block SHALL have parameter MMIO_SIZE, default 32'h00000100, MMIO window size in bytes (power of two).
REQ-006 The block SHALL have parameter TIMEOUT, default 1024, wait-state cycles before error completion (>=2).
REQ-007 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-008 The block SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-009 The block SHALL have ports m_valid, m_ready and m_err, output for ready/err, N_MASTERS wide, per-master request, one-cycle completion and error flag.
REQ-010 The block SHALL have ports m_addr and m_wdata, input, 32*N_MASTERS, and m_wstrb, input, 4*N_MASTERS; master i occupies slice i.
REQ-011 The block SHALL have port m_rdata, output, 32, read data shared by all masters, qualified by m_ready[i].
REQ-012 The block SHALL have SRAM ports: sram_start out 1, sram_busy in 1, sram_done in 1, sram_cmd out 8, sram_addr out 32, sram_wdata out 32, sram_wstrb out 4, sram_rdata in 32.
REQ-013 The block SHALL have MMIO ports: mmio_valid out 1, mmio_write out 1, mmio_addr out 32, mmio_wdata out 32, mmio_wstrb out 4, mmio_rdata in 32, mmio_ready in 1.
REQ-014 The block SHALL have port err_count, output, 16, saturating count of error completions.

Function
REQ-015 The block SHALL use FSM states IDLE, SRAM_WAIT, MMIO_WAIT and RESP; all outputs are registered.
REQ-016 In IDLE, the block SHALL grant round-robin among asserted m_valid, starting at (last_grant+1) mod N_MASTERS.
REQ-017 The grant SHALL capture the master's addr, wdata, wstrb and index in that cycle; a write is wstrb!=0.
REQ-018 SRAM hit SHALL be addr-SRAM_BASE < SRAM_SIZE (unsigned, 32-bit wrap); MMIO hit SHALL be addr-MMIO_BASE < MMIO_SIZE.
REQ-019 An SRAM hit SHALL pulse sram_start for one cycle on the next edge, with cmd 8'h02 for a write or 8'h01 for a read, and then enter SRAM_WAIT.
REQ-020 While sram_busy=1, the block SHALL NOT grant an SRAM-targeted request; the master remains pending and other masters' MMIO or unmapped requests may proceed.
REQ-021 An MMIO hit SHALL pulse mmio_valid for one cycle with the write, addr, wdata and wstrb fields, and then enter MMIO_WAIT.
REQ-022 An unmapped address SHALL go directly to RESP with m_rdata=0 and m_err=1.
REQ-023 On sram_done or mmio_ready in the matching WAIT state, the block SHALL latch the read data and enter RESP with m_err=0.
REQ-024 A wait counter SHALL reset on WAIT entry; when it reaches TIMEOUT-1 without completion, the block SHALL enter RESP with m_rdata=0 and m_err=1.
REQ-025 In RESP, m_ready[granted] SHALL be high for exactly one cycle, m_err is valid only in that cycle, and the block then returns to IDLE and updates last_grant.
REQ-026 Minimum latency SHALL be: grant at edge t, strobe at t+1, m_ready at done+1, and the next grant no earlier than one cycle after RESP.
REQ-027 sram_done or mmio_ready arriving outside its WAIT state, including after a timeout, SHALL be ignored.
REQ-028 If completion and timeout coincide, the block SHALL report completion (m_err=0).
REQ-029 err_count SHALL increment on each RESP with m_err=1 and saturate at 16'hFFFF.
REQ-030 With N_MASTERS=1, the block SHALL behave as a single-master controller with no arbitration bubble beyond REQ-026.

Reset
REQ-031 resetn=0 SHALL force state IDLE and all outputs, captured fields, wait counter and err_count to 0, and set last_grant to N_MASTERS-1 so master 0 has first priority.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no m_ready, and a late sram_done or mmio_ready after reset SHALL be ignored.

Structure
REQ-033 Package mem_pkg SHALL hold CMD_READ/CMD_WRITE, the FSM state encoding and default window constants.
REQ-034 A sub-module rr_arbiter SHALL be used, parameterised by N_MASTERS, with inputs req, last_grant and enable, and outputs one-hot grant and index.

Verification
REQ-035 A single master SRAM read at 0x00000010 with sram_done 3 cycles after start SHALL give m_ready[0] one cycle later, m_rdata=sram_rdata and m_err=0.
REQ-036 Masters 0 and 1 both valid continuously SHALL be granted alternately 0,1,0,1, with no master granted twice in a row.
REQ-037 A read at 0x40000000 SHALL give m_ready at t+1, m_rdata=0, m_err=1 and err_count=1, with no sram_start or mmio_valid.
REQ-038 An MMIO write to 0x80000004 with mmio_ready never asserted SHALL give m_ready with m_err=1 exactly TIMEOUT cycles after mmio_valid, and a later mmio_ready SHALL be ignored.
REQ-039 With sram_busy=1 and master 0 requesting SRAM and master 1 requesting MMIO, master 1 SHALL complete first and master 0 SHALL start after busy drops.
REQ-040 Asserting resetn=0 during SRAM_WAIT SHALL drive all outputs to 0 next cycle, and a subsequent sram_done SHALL produce no m_ready.
